// File: rtl/alu_out_stage_if.sv
// ALU output stage bus: ALU-side handshake in, write-back handshake out.
// Also exposes the architectural HI/LO registers.
interface alu_out_stage_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             branch_taken;
  logic             lo_en;
  logic             hi_en;
  logic [1:0]       alu_lo_hi;
  logic [4:0]       dest;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [4:0]       out_dest;
  logic             out_branch;

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  modport master (
    output in_valid,
    input  in_ready,
    output result,
    output result_hi,
    output branch_taken,
    output lo_en,
    output hi_en,
    output alu_lo_hi,
    output dest,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_dest,
    input  out_branch,
    input  hi_q,
    input  lo_q
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  result,
    input  result_hi,
    input  branch_taken,
    input  lo_en,
    input  hi_en,
    input  alu_lo_hi,
    input  dest,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_dest,
    output out_branch,
    output hi_q,
    output lo_q
  );

endinterface

// File: rtl/alu_out_stage.sv
// ALU output stage: HI/LO registers, write-back select, and a
// two-deep (output register + skid) buffer toward the register file.
module alu_out_stage #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  alu_out_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [4:0]       dest;
    logic             br;
  } entry_t;

  state_t           state_q;
  state_t           state_d;
  entry_t           out_q;
  entry_t           skid_q;
  entry_t           new_e;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] sel_data;

  logic             accept;
  logic             drain;
  logic             load_out_new;
  logic             load_out_skid;
  logic             load_skid;

  // Ready never looks at out_ready; it only reflects free buffer space.
  assign bus.in_ready   = !rst && (state_q != TWO);
  assign bus.out_valid  = (state_q != EMPTY);
  assign bus.out_data   = out_q.data;
  assign bus.out_dest   = out_q.dest;
  assign bus.out_branch = out_q.br;
  assign bus.hi_q       = hi_r;
  assign bus.lo_q       = lo_r;

  assign accept = bus.in_valid && bus.in_ready;
  assign drain  = bus.out_valid && bus.out_ready;

  // Write-back select sees HI/LO before this cycle's update.
  always_comb begin
    sel_data = bus.result;
    unique case (1'b1)
      (bus.alu_lo_hi == 2'b01): sel_data = lo_r;
      (bus.alu_lo_hi == 2'b10): sel_data = hi_r;
      default:                  sel_data = bus.result;
    endcase
  end

  assign new_e = '{data: sel_data, dest: bus.dest, br: bus.branch_taken};

  // Buffer occupancy next-state and register load enables.
  always_comb begin
    state_d       = state_q;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d      = ONE;
          load_out_new = 1'b1;
        end
      end
      ONE: begin
        if (accept && !drain) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (accept && drain) begin
          state_d      = ONE;
          load_out_new = 1'b1;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          state_d       = ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State, buffered entries and HI/LO; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else begin
      state_q <= state_d;
      if (load_out_new) begin
        out_q <= new_e;
      end else if (load_out_skid) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= new_e;
      end
      if (accept && bus.lo_en) begin
        lo_r <= bus.result;
      end
      if (accept && bus.hi_en) begin
        hi_r <= bus.result_hi;
      end
    end
  end

endmodule

// File: tb/tb_alu_out_stage.sv
// Testbench for alu_out_stage: directed scenarios plus a random run
// against a queue-based model of the write-back stream and HI/LO.
module tb_alu_out_stage;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] data;
    logic [4:0]   dest;
    logic         br;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  ent_t         exp_q[$];
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  alu_out_stage_if #(.WIDTH(W)) bus ();

  alu_out_stage #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock and update the model from the driven inputs.
  task automatic tick();
    bit   acc;
    bit   drn;
    ent_t e;
    acc = !rst && bus.in_valid && (exp_q.size() < 2);
    drn = (exp_q.size() > 0) && bus.out_ready;
    e.dest = bus.dest;
    e.br   = bus.branch_taken;
    if (bus.alu_lo_hi == 2'b01)      e.data = m_lo;
    else if (bus.alu_lo_hi == 2'b10) e.data = m_hi;
    else                             e.data = bus.result;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_hi = '0;
      m_lo = '0;
    end else begin
      if (drn) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(e);
        if (bus.lo_en) m_lo = bus.result;
        if (bus.hi_en) m_hi = bus.result_hi;
      end
    end
    #1;
  endtask

  task automatic idle_in();
    bus.in_valid     = 1'b0;
    bus.lo_en        = 1'b0;
    bus.hi_en        = 1'b0;
    bus.alu_lo_hi    = 2'b00;
    bus.result       = '0;
    bus.result_hi    = '0;
    bus.branch_taken = 1'b0;
    bus.dest         = '0;
  endtask

  task automatic test_reset();
    idle_in();
    bus.out_ready = 1'b1;
    rst = 1'b1;
    bus.in_valid = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_ready: got %b want 0", bus.in_ready);
    end
    tick();
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 ||
        bus.out_dest !== 5'd0 || bus.out_branch !== 1'b0) begin
      errors++;
      $display("FAIL rst_out: got v=%b d=%h r=%0d b=%b want zeros",
               bus.out_valid, bus.out_data, bus.out_dest, bus.out_branch);
    end
    checks++;
    if (bus.hi_q !== '0 || bus.lo_q !== '0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_hilo: got hi=%h lo=%h rdy=%b want 0 0 1",
               bus.hi_q, bus.lo_q, bus.in_ready);
    end
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.result    = 32'h5;
    bus.dest      = 5'd3;
    tick();
    idle_in();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h5 ||
        bus.out_dest !== 5'd3) begin
      errors++;
      $display("FAIL basic: got v=%b d=%h r=%0d want 1 5 3",
               bus.out_valid, bus.out_data, bus.out_dest);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: got v=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_hilo();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.lo_en     = 1'b1;
    bus.hi_en     = 1'b1;
    bus.result    = 32'h1111_1111;
    bus.result_hi = 32'h2222_2222;
    bus.dest      = 5'd1;
    tick();
    bus.lo_en     = 1'b0;
    bus.hi_en     = 1'b0;
    bus.result    = 32'h0;
    bus.result_hi = 32'h0;
    bus.alu_lo_hi = 2'b10;
    bus.dest      = 5'd2;
    tick();
    idle_in();
    checks++;
    if (bus.out_data !== 32'h2222_2222 || bus.out_dest !== 5'd2) begin
      errors++;
      $display("FAIL hi_sel: got %h r=%0d want 22222222 2",
               bus.out_data, bus.out_dest);
    end
    checks++;
    if (bus.hi_q !== 32'h2222_2222 || bus.lo_q !== 32'h1111_1111) begin
      errors++;
      $display("FAIL hilo_regs: got hi=%h lo=%h want 22222222 11111111",
               bus.hi_q, bus.lo_q);
    end
    tick();
  endtask

  task automatic test_same_cycle();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.lo_en     = 1'b1;
    bus.result    = 32'd9;
    tick();
    bus.alu_lo_hi = 2'b01;
    bus.result    = 32'd7;
    bus.dest      = 5'd4;
    tick();
    idle_in();
    checks++;
    if (bus.out_data !== 32'd9 || bus.lo_q !== 32'd7) begin
      errors++;
      $display("FAIL lo_bypass: got d=%h lo=%h want 9 7",
               bus.out_data, bus.lo_q);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.result    = 32'hA;
    bus.dest      = 5'd10;
    tick();
    bus.result = 32'hB;
    bus.dest   = 5'd11;
    tick();
    bus.result = 32'hC;
    bus.dest   = 5'd12;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_data !== 32'hA) begin
      errors++;
      $display("FAIL full: got rdy=%b d=%h want 0 A",
               bus.in_ready, bus.out_data);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA ||
        bus.out_dest !== 5'd10 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold: got v=%b d=%h r=%0d rdy=%b want 1 A 10 0",
               bus.out_valid, bus.out_data, bus.out_dest, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.out_data !== 32'hB || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_a: got d=%h rdy=%b want B 1",
               bus.out_data, bus.in_ready);
    end
    tick();
    idle_in();
    checks++;
    if (bus.out_data !== 32'hC || bus.out_dest !== 5'd12 ||
        bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL drain_b: got v=%b d=%h r=%0d want 1 C 12",
               bus.out_valid, bus.out_data, bus.out_dest);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_c: got v=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.lo_en     = 1'b1;
    bus.hi_en     = 1'b1;
    bus.result    = 32'h33;
    bus.result_hi = 32'h44;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_in();
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.hi_q !== '0 || bus.lo_q !== '0 ||
        bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst: got v=%b hi=%h lo=%h rdy=%b want 0 0 0 1",
               bus.out_valid, bus.hi_q, bus.lo_q, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.result   = 32'h77;
    bus.dest     = 5'd7;
    tick();
    idle_in();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h77) begin
      errors++;
      $display("FAIL post_rst: got v=%b d=%h want 1 77",
               bus.out_valid, bus.out_data);
    end
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int bad;
    for (int i = 0; i < 400; i++) begin
      rst              = ($urandom_range(0, 59) == 0);
      bus.in_valid     = $urandom_range(0, 2) != 0;
      bus.out_ready    = $urandom_range(0, 2) != 0;
      bus.lo_en        = $urandom_range(0, 1);
      bus.hi_en        = $urandom_range(0, 1);
      bus.alu_lo_hi    = 2'($urandom_range(0, 3));
      bus.result       = $urandom;
      bus.result_hi    = $urandom;
      bus.branch_taken = $urandom_range(0, 1);
      bus.dest         = 5'($urandom_range(0, 31));
      tick();
      rst = 1'b0;
      #1;
      bad = 0;
      if (bus.out_valid !== (exp_q.size() > 0)) bad = 1;
      if (bus.in_ready !== (exp_q.size() < 2)) bad = 1;
      if (bus.hi_q !== m_hi || bus.lo_q !== m_lo) bad = 1;
      if (exp_q.size() > 0) begin
        if (bus.out_data !== exp_q[0].data ||
            bus.out_dest !== exp_q[0].dest ||
            bus.out_branch !== exp_q[0].br) bad = 1;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rand[%0d]: got v=%b rdy=%b d=%h r=%0d b=%b hi=%h lo=%h exp n=%0d hi=%h lo=%h",
                 i, bus.out_valid, bus.in_ready, bus.out_data, bus.out_dest,
                 bus.out_branch, bus.hi_q, bus.lo_q, exp_q.size(), m_hi, m_lo);
        if (exp_q.size() > 0)
          $display("  expected head d=%h r=%0d b=%b",
                   exp_q[0].data, exp_q[0].dest, exp_q[0].br);
      end
    end
  endtask

  initial begin
    m_hi = '0;
    m_lo = '0;
    test_reset();
    test_basic();
    test_hilo();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_out_stage.md
ALU_OUT_STAGE -- requirements
Module: alu_out_stage

Interface
REQ-001 SHALL have parameter: WIDTH, 32, datapath width of ALU result, HI, LO and write-back data.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  ALU result presented this cycle.
REQ-005 SHALL have port: in_ready  output  1  stage can accept ALU result this cycle.
REQ-006 SHALL have port: result  input  WIDTH  ALU low result word.
REQ-007 SHALL have port: result_hi  input  WIDTH  ALU high result word (multiply upper half).
REQ-008 SHALL have port: branch_taken  input  1  ALU branch compare outcome.
REQ-009 SHALL have port: lo_en  input  1  write result into LO on accept.
REQ-010 SHALL have port: hi_en  input  1  write result_hi into HI on accept.
REQ-011 SHALL have port: alu_lo_hi  input  2  write-back select: 00 result, 01 LO, 10 HI, 11 result.
REQ-012 SHALL have port: dest  input  5  destination register index, carried with the data.
REQ-013 SHALL have port: out_valid  output  1  write-back entry valid.
REQ-014 SHALL have port: out_ready  input  1  register-file side accepts entry.
REQ-015 SHALL have port: out_data  output  WIDTH  selected write-back data.
REQ-016 SHALL have port: out_dest  output  5  destination index of current entry.
REQ-017 SHALL have port: out_branch  output  1  latched branch_taken of current entry.
REQ-018 SHALL have ports: hi_q, lo_q  output  WIDTH each  current HI and LO register contents.

Function
REQ-019 Accept SHALL occur when in_valid && in_ready; drain SHALL occur when out_valid && out_ready.
REQ-020 On accept, LO SHALL load result iff lo_en and HI SHALL load result_hi iff hi_en, independently.
REQ-021 Entry data SHALL be formed at accept: sel 00/11 -> result; 01 -> LO; 10 -> HI, using HI/LO values before that same cycle's update.
REQ-022 Buffering SHALL be an output register plus one-entry skid buffer; state machine EMPTY, ONE, TWO.
REQ-023 EMPTY: accept -> ONE; no accept -> EMPTY.
REQ-024 ONE: accept without drain -> TWO (new entry to skid); drain without accept -> EMPTY; accept with drain -> ONE holding the new entry; neither -> ONE.
REQ-025 TWO: drain -> ONE with skid entry moved to output register; no drain -> TWO.
REQ-026 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO and 0 while rst is high; in_ready SHALL not depend combinationally on out_ready.
REQ-027 out_valid SHALL be 1 in ONE and TWO; latency accept -> out_valid SHALL be exactly 1 cycle from EMPTY.
REQ-028 While out_valid && !out_ready, out_data, out_dest and out_branch SHALL remain stable.
REQ-029 Entries SHALL drain in accept order; none SHALL be dropped or duplicated.
REQ-030 in_valid without in_ready SHALL cause no HI/LO update and no entry.

Reset
REQ-031 On rst: state EMPTY, out_valid 0, out_data 0, out_dest 0, out_branch 0, HI 0, LO 0.
REQ-032 rst mid-operation SHALL discard all buffered entries and any concurrent accept, including its HI/LO writes.
REQ-033 First accept SHALL be possible in the cycle after rst deasserts.

Verification
REQ-034 Reset, then result=0x0000_0005, alu_lo_hi=00, dest=3, out_ready=1 -> next cycle out_valid=1, out_data=5, out_dest=3.
REQ-035 Accept lo_en=hi_en=1, result=0x1111_1111, result_hi=0x2222_2222; next accept alu_lo_hi=10 -> out_data=0x2222_2222; hi_q=0x2222_2222, lo_q=0x1111_1111.
REQ-036 Same cycle lo_en=1, alu_lo_hi=01, result=7 with LO=9 -> out_data=9, lo_q=7 afterwards.
REQ-037 out_ready=0, three back-to-back in_valid entries A,B,C -> A,B held, in_ready=0, C not accepted; raise out_ready -> A then B drain, C accepted after, order A,B,C.
REQ-038 State TWO, assert rst one cycle -> out_valid=0, hi_q=lo_q=0, in_ready=1 next cycle.
